// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared FSM state encoding, port ids and default widths for the register bank arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_HOST  = 1'b0;
    localparam logic PORT_SPI   = 1'b1;
    localparam int   ADDR_W_DEF = 7;
    localparam int   DATA_W_DEF = 8;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; a lone requester wins, on contention the port not granted last wins.
module rr_arb2
    import reg_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    // Grant is a pure function of the current requests and the previous winner.
    always_comb begin
        o_grant = !i_enable ? 2'b00 :
                  (i_valid == 2'b11) ? ((i_last_grant == PORT_SPI) ? 2'b01 : 2'b10) :
                  i_valid;
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: shares one register bank between host (port 0) and SPI (port 1), one access per 3 cycles.
// Optional REG_ARB_WRITE_PROTECT_EN: port-1 writes at or above PROT_BASE are suppressed and flagged with rsp_err.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PROT_BASE = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                bank_wr,
    output logic [ADDR_W-1:0]   bank_addr,
    output logic [DATA_W-1:0]   bank_wdata,
    input  logic [DATA_W-1:0]   bank_rdata
);

`ifdef REG_ARB_WRITE_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] PROT_A = ADDR_W'(PROT_BASE);

    state_t              r_state;
    state_t              w_next;
    logic                r_port;
    logic                r_we;
    logic                r_last_grant;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_sel;
    logic                w_prot;

    rr_arb2 u_arb (
        .i_valid      (req_valid),
        .i_last_grant (r_last_grant),
        .i_enable     (r_state == IDLE),
        .o_grant      (w_grant)
    );

    assign req_ready  = w_grant;
    assign w_accept   = |(req_valid & w_grant);
    assign w_sel      = w_grant[1];
    assign w_prot     = PROT_EN & (r_port == PORT_SPI) & r_we & (r_addr >= PROT_A);
    assign bank_wr    = (r_state == ACCESS) & r_we & ~w_prot;
    assign bank_addr  = r_addr;
    assign bank_wdata = r_wdata;
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;

    // State register; async reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Fixed IDLE -> ACCESS -> RESP walk; the response pulse goes to the latched port only.
    always_comb begin
        w_next    = IDLE;
        rsp_valid = 2'b00;
        w_next    = (r_state == IDLE)   ? (w_accept ? ACCESS : IDLE) :
                    (r_state == ACCESS) ? RESP : IDLE;
        rsp_valid = (r_state != RESP) ? 2'b00 : ((r_port == PORT_SPI) ? 2'b10 : 2'b01);
    end

    // Capture the accepted request, then the response data/error as the bank access completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_port       <= PORT_HOST;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= PORT_SPI;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_port       <= w_sel;
            r_we         <= req_we[w_sel];
            r_addr       <= w_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            r_wdata      <= w_sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            r_last_grant <= w_sel;
        end else if (r_state == ACCESS) begin
            r_rdata      <= r_we ? r_wdata : bank_rdata;
            r_err        <= w_prot;
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed test of reg_bank_arbiter with a bank model, cycle model and response scoreboard.
module tb_reg_bank_arbiter;

`ifdef REG_ARB_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        logic       port;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        bank_wr;
    logic [6:0]  bank_addr;
    logic [7:0]  bank_wdata;
    logic [7:0]  bank_rdata;

    logic [7:0]  bank [128];
    logic [7:0]  m_mem [128];
    exp_t        sbq [$];
    logic        dut_grants [$];
    int          acc_cyc [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    int          busy = 0;
    logic        m_last = 1'b1;
    logic        m_port, m_we, m_prot;
    logic [6:0]  m_addr;
    logic [7:0]  m_wdata;

    reg_bank_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bank_wr    (bank_wr),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bank_wr) bank[bank_addr] <= bank_wdata;
    assign bank_rdata = bank[bank_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Cycle model of the arbiter, checked every cycle away from the clock edge.
    always @(negedge clk) begin
        logic [1:0] exp_ready;
        exp_t       e;
        if (rst) begin
            busy   = 0;
            m_last = 1'b1;
            sbq.delete();
        end else begin
            exp_ready = (busy != 0) ? 2'b00 :
                        (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("bank_wr", 32'(bank_wr), 32'(busy == 2 && m_we && !m_prot));
            if (busy == 2) begin
                chk("bank_addr", 32'(bank_addr), 32'(m_addr));
                if (m_we && !m_prot) m_mem[m_addr] = m_wdata;
            end
            chk("rsp_valid", 32'(rsp_valid), (busy == 1) ? (m_port ? 32'd2 : 32'd1) : 32'd0);
            if (rsp_valid != 2'b00) begin
                rsp_cnt++;
                if (sbq.size() == 0) chk("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("rsp_port", 32'(rsp_valid[1]), 32'(e.port));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            if (|(req_valid & req_ready)) begin
                dut_grants.push_back(req_ready[1]);
                acc_cyc.push_back(cyc);
            end
            if (busy != 0) busy--;
            else if (|(req_valid & exp_ready)) begin
                m_port  = exp_ready[1];
                m_we    = req_we[m_port];
                m_addr  = m_port ? req_addr[13:7] : req_addr[6:0];
                m_wdata = m_port ? req_wdata[15:8] : req_wdata[7:0];
                m_prot  = PROT && m_port && m_we && (m_addr >= 7'd64);
                sbq.push_back('{m_port, m_we ? m_wdata : m_mem[m_addr], m_prot});
                m_last  = m_port;
                busy    = 2;
                acc_cnt++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_bank_wr", 32'(bank_wr), 32'd0);
        chk("rst_bank_addr", 32'(bank_addr), 32'd0);
        chk("rst_bank_wdata", 32'(bank_wdata), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Raise one port's request and hold it until accepted; returns just after the accept edge.
    task automatic req(input int p, input logic we, input logic [6:0] a, input logic [7:0] d);
        int base = acc_cnt;
        int n = 0;
        req_we[p]          = we;
        req_addr[p*7 +: 7] = a;
        req_wdata[p*8 +: 8] = d;
        req_valid[p]       = 1'b1;
        @(posedge clk);
        while (acc_cnt == base && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1 req_valid[p] = 1'b0;
        chk("accept_timeout", 32'(acc_cnt != base), 32'd1);
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", 32'(rsp_cnt >= target), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int p, input logic we, input logic [6:0] a, input logic [7:0] d);
        int base = rsp_cnt;
        req(p, we, a, d);
        wait_rsp(base + 1);
    endtask

    // Both ports request reads and stay valid until n accepts have happened.
    task automatic hold_both(input int n, input logic [6:0] a0, input logic [6:0] a1);
        int abase = acc_cnt;
        int rbase = rsp_cnt;
        int k = 0;
        req_we    = 2'b00;
        req_addr  = {a1, a0};
        req_valid = 2'b11;
        @(posedge clk);
        while (acc_cnt < abase + n && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1 req_valid = 2'b00;
        chk("hold_accepts", 32'(acc_cnt - abase), 32'(n));
        wait_rsp(rbase + n);
    endtask

    initial begin
        int g0, ab, rb;
        for (int i = 0; i < 128; i++) begin
            bank[i]  = 8'h00;
            m_mem[i] = 8'h00;
        end
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // 1: host write then read back
        txn(0, 1'b1, 7'h05, 8'hA5);
        chk("t1_bank_mem", 32'(bank[5]), 32'hA5);
        txn(0, 1'b0, 7'h05, 8'h00);
        chk("t1_read", 32'(rsp_rdata), 32'hA5);

        // 2: contention right after reset, host first, SPI three cycles later
        do_reset();
        g0 = dut_grants.size();
        hold_both(2, 7'h01, 7'h02);
        chk("t2_first", 32'(dut_grants[g0]), 32'd0);
        chk("t2_second", 32'(dut_grants[g0+1]), 32'd1);
        chk("t2_spacing", 32'(acc_cyc[g0+1] - acc_cyc[g0]), 32'd3);

        // 3: sustained contention alternates grants
        g0 = dut_grants.size();
        hold_both(6, 7'h05, 7'h02);
        for (int i = 0; i < 6; i++) chk("t3_grant", 32'(dut_grants[g0+i]), 32'(i % 2));

        // 4: SPI write into the protectable range
        txn(1, 1'b1, 7'h40, 8'h3C);
        chk("t4_err", 32'(rsp_err), PROT ? 32'd1 : 32'd0);
        txn(0, 1'b0, 7'h40, 8'h00);
        chk("t4_read", 32'(rsp_rdata), PROT ? 32'h00 : 32'h3C);

        // 5: reset while the write is in ACCESS drops it silently
        rb = rsp_cnt;
        req(0, 1'b1, 7'h10, 8'hFF);
        rst = 1'b1;
        #1 chk("t5_bank_wr", 32'(bank_wr), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("t5_no_rsp", 32'(rsp_cnt), 32'(rb));
        chk("t5_rdata_cleared", 32'(rsp_rdata), 32'd0);
        txn(0, 1'b0, 7'h10, 8'h00);
        chk("t5_read", 32'(rsp_rdata), 32'h00);

        // 6: host valid raised during SPI RESP and withdrawn before any accept edge
        ab = acc_cnt;
        rb = rsp_cnt;
        req(1, 1'b0, 7'h02, 8'h00);
        @(posedge clk);
        #1;
        req_we[0]      = 1'b0;
        req_addr[6:0]  = 7'h07;
        req_valid[0]   = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_accepts", 32'(acc_cnt - ab), 32'd1);
        chk("t6_rsps", 32'(rsp_cnt - rb), 32'd1);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
